// File: rtl/priv_1_12_trap_sequencer.sv
// Machine-mode trap/mret sequencer.
// Captures one request and waits for the pipeline to drain.
// It then emits the CSR write strobes (trap) or the mret commit strobe.
// Finally it redirects the pipeline to the handler or return address.
module priv_1_12_trap_sequencer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        exc_req,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_tval,
    input  logic [31:0] epc,
    input  logic        int_req,
    input  logic [3:0]  int_cause,
    input  logic        mret,
    input  logic        pipe_clear,
    input  logic [31:0] curr_mtvec,
    input  logic [31:0] curr_mepc,
    output logic        inject_mcause,
    output logic        inject_mepc,
    output logic        inject_mtval,
    output logic        inject_mstatus,
    output logic [31:0] next_mcause,
    output logic [31:0] next_mepc,
    output logic [31:0] next_mtval,
    output logic        mret_commit,
    output logic        insert_pc,
    output logic [31:0] priv_pc,
    output logic        busy,
    output logic        wait_timeout
);

    localparam logic [7:0] MAX_W = MAX_WAIT[7:0];

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_CLEAR = 2'd1,
        S_INJECT     = 2'd2,
        S_REDIRECT   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        is_int_q, is_int_d;
    logic        is_mret_q, is_mret_d;
    logic [3:0]  cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] tval_q, tval_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wto_q, wto_d;
    logic [31:0] priv_pc_q, priv_pc_d;
    logic [31:0] tvec_base;
    logic [31:0] target_pc;

    // Handler / return target, evaluated while in INJECT.
    // Only vectored interrupts add an offset; reserved modes behave as direct mode.
    always_comb begin
        tvec_base = {curr_mtvec[31:2], 2'b00};
        target_pc = tvec_base;
        if (is_mret_q) begin
            target_pc = curr_mepc;
        end else if (is_int_q && (curr_mtvec[1:0] == 2'b01)) begin
            target_pc = tvec_base + {26'd0, cause_q, 2'b00};
        end
    end

    // Next-state, capture, wait counter and redirect-target logic.
    always_comb begin
        state_d   = state_q;
        is_int_d  = is_int_q;
        is_mret_d = is_mret_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        tval_d    = tval_q;
        cnt_d     = cnt_q;
        wto_d     = wto_q;
        priv_pc_d = priv_pc_q;
        case (state_q)
            S_IDLE: begin
                if (exc_req || int_req || mret) begin
                    state_d   = S_WAIT_CLEAR;
                    // Exception wins over interrupt, interrupt over mret; losers are dropped.
                    is_int_d  = !exc_req && int_req;
                    is_mret_d = !exc_req && !int_req && mret;
                    cause_d   = exc_req ? exc_cause : (int_req ? int_cause : 4'd0);
                    epc_d     = epc;
                    tval_d    = exc_req ? exc_tval : 32'd0;
                    // The first WAIT_CLEAR cycle already counts as one.
                    cnt_d     = 8'd1;
                    wto_d     = (8'd1 >= MAX_W);
                end
            end
            S_WAIT_CLEAR: begin
                if (pipe_clear) begin
                    state_d = S_INJECT;
                end
                if (cnt_q < MAX_W) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (cnt_d >= MAX_W) begin
                    wto_d = 1'b1;
                end
            end
            S_INJECT: begin
                state_d   = S_REDIRECT;
                priv_pc_d = target_pc;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
                wto_d   = 1'b0;
            end
        endcase
    end

    // State and captured-request registers; an async reset aborts any sequence.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            is_int_q  <= 1'b0;
            is_mret_q <= 1'b0;
            cause_q   <= 4'd0;
            epc_q     <= 32'd0;
            tval_q    <= 32'd0;
            cnt_q     <= 8'd0;
            wto_q     <= 1'b0;
            priv_pc_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            is_int_q  <= is_int_d;
            is_mret_q <= is_mret_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            tval_q    <= tval_d;
            cnt_q     <= cnt_d;
            wto_q     <= wto_d;
            priv_pc_q <= priv_pc_d;
        end
    end

    wire in_inject = (state_q == S_INJECT);

    assign inject_mcause  = in_inject && !is_mret_q;
    assign inject_mepc    = in_inject && !is_mret_q;
    assign inject_mtval   = in_inject && !is_mret_q;
    assign inject_mstatus = in_inject && !is_mret_q;
    assign mret_commit    = in_inject && is_mret_q;
    assign insert_pc      = (state_q == S_REDIRECT);
    assign busy           = (state_q != S_IDLE);
    assign wait_timeout   = wto_q;
    assign priv_pc        = priv_pc_q;
    assign next_mcause    = {is_int_q, 27'd0, cause_q};
    assign next_mepc      = epc_q;
    assign next_mtval     = tval_q;

endmodule

// File: tb/tb_priv_1_12_trap_sequencer.sv
// Scoreboard bench for the trap sequencer.
// Expected sequences are queued when a request is driven.
// They are retired when the DUT strobes INJECT and REDIRECT.
module tb_priv_1_12_trap_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        exc_req = 1'b0;
    logic [3:0]  exc_cause = 4'd0;
    logic [31:0] exc_tval = 32'd0;
    logic [31:0] epc = 32'd0;
    logic        int_req = 1'b0;
    logic [3:0]  int_cause = 4'd0;
    logic        mret = 1'b0;
    logic        pipe_clear = 1'b0;
    logic [31:0] curr_mtvec = 32'd0;
    logic [31:0] curr_mepc = 32'd0;
    logic        inject_mcause, inject_mepc, inject_mtval, inject_mstatus;
    logic [31:0] next_mcause, next_mepc, next_mtval;
    logic        mret_commit, insert_pc, busy, wait_timeout;
    logic [31:0] priv_pc;

    priv_1_12_trap_sequencer #(.MAX_WAIT(15)) dut (
        .CLK(CLK), .RST(RST),
        .exc_req(exc_req), .exc_cause(exc_cause), .exc_tval(exc_tval), .epc(epc),
        .int_req(int_req), .int_cause(int_cause), .mret(mret), .pipe_clear(pipe_clear),
        .curr_mtvec(curr_mtvec), .curr_mepc(curr_mepc),
        .inject_mcause(inject_mcause), .inject_mepc(inject_mepc),
        .inject_mtval(inject_mtval), .inject_mstatus(inject_mstatus),
        .next_mcause(next_mcause), .next_mepc(next_mepc), .next_mtval(next_mtval),
        .mret_commit(mret_commit), .insert_pc(insert_pc), .priv_pc(priv_pc),
        .busy(busy), .wait_timeout(wait_timeout)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        is_mret;
        logic [31:0] mcause;
        logic [31:0] mepc;
        logic [31:0] mtval;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [4:0] mon_strb;
    int n_tests = 0;
    int n_fail = 0;
    int n_pushed = 0;
    int n_redir = 0;
    int lat;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_pc(input logic is_mret, input logic is_int,
                                             input logic [3:0] cause, input logic [31:0] tvec,
                                             input logic [31:0] mepc_v);
        logic [31:0] base;
        base = {tvec[31:2], 2'b00};
        if (is_mret) return mepc_v;
        if (is_int && (tvec[1:0] == 2'b01)) return base + 32'(cause) * 32'd4;
        return base;
    endfunction

    // Drive one request cycle and queue what the DUT must produce for it.
    task automatic issue(input logic e, input logic [3:0] ec, input logic [31:0] tv,
                         input logic [31:0] pc, input logic i, input logic [3:0] ic,
                         input logic m, input logic [31:0] tvec, input logic [31:0] mepc_v);
        exp_t x;
        curr_mtvec = tvec;
        curr_mepc  = mepc_v;
        exc_req = e; exc_cause = ec; exc_tval = tv; epc = pc;
        int_req = i; int_cause = ic; mret = m;
        x.is_mret = !e && !i && m;
        x.mcause  = e ? {28'd0, ec} : {1'b1, 27'd0, ic};
        x.mepc    = pc;
        x.mtval   = e ? tv : 32'd0;
        x.pc      = model_pc(x.is_mret, !e && i, e ? ec : ic, tvec, mepc_v);
        sb.push_back(x);
        n_pushed++;
        @(posedge CLK); #1;
        exc_req = 1'b0; int_req = 1'b0; mret = 1'b0;
    endtask

    task automatic run_lat(output int l);
        l = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge CLK);
            if (insert_pc) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (!busy) break;
        end
        if (busy) chk("idle_wait_expired", busy, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_strobes"}, {inject_mcause, inject_mepc, inject_mtval, inject_mstatus,
                                mret_commit, insert_pc, busy, wait_timeout}, 0);
        chk({tag, "_pc_cause"}, {priv_pc, next_mcause}, 0);
        chk({tag, "_mepc_mtval"}, {next_mepc, next_mtval}, 0);
    endtask

    // Scoreboard retirement: INJECT checks strobes/CSR values, REDIRECT pops and checks priv_pc.
    always @(negedge CLK) begin
        if (!RST) begin
            mon_strb = {inject_mcause, inject_mepc, inject_mtval, inject_mstatus, mret_commit};
            if (mon_strb != 5'd0) begin
                if (sb.size() == 0) begin
                    chk("inject_unexpected", mon_strb, 0);
                end else if (sb[0].is_mret) begin
                    chk("mret_strobes", mon_strb, 5'b00001);
                end else begin
                    chk("trap_strobes", mon_strb, 5'b11110);
                    chk("next_mcause", next_mcause, sb[0].mcause);
                    chk("next_mepc", next_mepc, sb[0].mepc);
                    chk("next_mtval", next_mtval, sb[0].mtval);
                end
            end
            if (insert_pc) begin
                if (sb.size() == 0) begin
                    chk("redirect_unexpected", insert_pc, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("priv_pc", priv_pc, mon_e.pc);
                    n_redir++;
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge CLK);
        chk_all_zero("reset");
        RST = 1'b0;
        pipe_clear = 1'b1;

        // Exception, mode 01: direct target, minimum latency.
        issue(1, 4'd2, 32'hDEAD, 32'h100, 0, 0, 0, 32'h8000_0001, 0);
        run_lat(lat);
        chk("lat_exc", lat, 3);
        wait_idle();
        repeat (2) @(negedge CLK);
        chk("priv_pc_hold", priv_pc, 32'h8000_0000);

        // Vectored interrupts, including 32-bit wraparound.
        issue(0, 0, 32'h55, 32'h200, 1, 4'd7, 0, 32'h8000_0001, 0);
        wait_idle();
        issue(0, 0, 0, 32'h204, 1, 4'hF, 0, 32'hFFFF_FFFD, 0);
        wait_idle();
        issue(0, 0, 0, 32'h208, 1, 4'hF, 0, 32'hFFFF_FFF1, 0);
        wait_idle();
        // Reserved modes 10/11 behave as direct.
        issue(0, 0, 0, 32'h20C, 1, 4'd3, 0, 32'h4000_0002, 0);
        wait_idle();
        issue(1, 4'd5, 32'h77, 32'h210, 0, 0, 0, 32'h4000_0103, 0);
        wait_idle();

        // All three requests at once: exception only.
        issue(1, 4'hB, 32'h1234, 32'h300, 1, 4'd5, 1, 32'h8000_0001, 32'h7777);
        wait_idle();

        // mret, with a second mret raised while busy.
        pipe_clear = 1'b0;
        issue(0, 0, 0, 0, 0, 0, 1, 32'h8000_0001, 32'h2000);
        repeat (3) @(negedge CLK);
        mret = 1'b1;
        @(negedge CLK);
        mret = 1'b0;
        pipe_clear = 1'b1;
        wait_idle();
        repeat (3) @(negedge CLK);
        chk("mret_busy_ignored", busy, 0);

        // Watchdog: pipe_clear low for 20 cycles; a competing request mid-wait is ignored.
        pipe_clear = 1'b0;
        issue(1, 4'h5, 32'hF00D, 32'h600, 0, 0, 0, 32'h8000_0100, 0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (k == 1) chk("busy_wait", busy, 1);
            if (k == 5) begin exc_req = 1'b1; exc_cause = 4'h9; exc_tval = 32'h1; end
            if (k == 6) exc_req = 1'b0;
            if (k == 14) chk("wto_c14", wait_timeout, 0);
            if (k == 15) chk("wto_c15", wait_timeout, 1);
            if (k == 20) chk("wto_c20", wait_timeout, 1);
        end
        pipe_clear = 1'b1;
        wait_idle();
        chk("wto_idle", wait_timeout, 0);

        // Request during REDIRECT ignored; request in the first IDLE cycle accepted.
        issue(1, 4'd1, 32'hA, 32'h400, 0, 0, 0, 32'h0000_1000, 0);
        run_lat(lat);
        int_req = 1'b1;
        int_cause = 4'd3;
        @(posedge CLK); #1;
        chk("redirect_req_ignored", busy, 0);
        issue(0, 0, 0, 32'h404, 1, 4'd6, 0, 32'h0000_1001, 0);
        run_lat(lat);
        chk("lat_first_idle", lat, 3);
        wait_idle();

        // Reset in WAIT_CLEAR aborts silently; the next request runs normally.
        pipe_clear = 1'b0;
        issue(1, 4'd3, 32'h99, 32'h480, 0, 0, 0, 32'h0000_3000, 0);
        repeat (3) @(negedge CLK);
        #2 RST = 1'b1;
        #1 chk_all_zero("mid_reset");
        sb.delete();
        n_pushed--;
        @(negedge CLK);
        #2 RST = 1'b0;
        pipe_clear = 1'b1;
        issue(1, 4'd6, 32'hBEEF, 32'h500, 0, 0, 0, 32'h0000_2000, 0);
        run_lat(lat);
        chk("lat_after_reset", lat, 3);
        wait_idle();

        repeat (2) @(negedge CLK);
        chk("sb_drain", sb.size(), 0);
        chk("redirect_count", n_redir, n_pushed);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
